agc_timepulse_gen: RTL and testbench
====================================

Name: agc_timepulse_gen

Overview:
Timing generator directly upstream of the NOR-gate network in the FPGA-target build. It divides the fast FPGA clock into gate-update phases and the twelve AGC time pulses T01..T12 that drive the gate logic. It also supports free-run, halt-at-MCT-boundary and single-MCT step, and keeps a wrapping MCT scaler count.

Parameters:
DIV, 4, clk cycles per phase; legal range >= 1.
PH, 2, phases per time pulse; legal range >= 1.
SCALER_W, 17, width of the MCT scaler counter.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
run  in  1  level; 1 = run continuously, 0 = halt at the next MCT boundary.
step  in  1  single-cycle request for exactly one MCT while halted.
tp  out  12  one-hot time pulse; bit 0 = T01, bit 11 = T12; all-zero while halted.
ph  out  clog2(PH) (min 1)  phase index within current time pulse.
phase_en  out  1  one-cycle strobe on the last clk cycle of each phase; gates gate-network updates.
mct_done  out  1  one-cycle strobe on the last clk cycle of T12.
busy  out  1  1 while in RUN.
scaler  out  SCALER_W  count of completed MCTs; wraps.

Behaviour:
- Reset (rst=0, async): state HALT; tp=0, ph=0, div_cnt=0, phase_en=0, mct_done=0, busy=0, scaler=0. Release is synchronous to the next clk edge.
- States: HALT, RUN.
- HALT -> RUN: on an edge where run=1 or step=1. At that edge: tp<=12'h001, ph<=0, div_cnt<=0, busy<=1. step_only<=~run. First T01 cycle is the cycle after the sampling edge.
- In HALT, tp, ph, div_cnt and scaler hold. phase_en=0 and mct_done=0.
- RUN prescaler: div_cnt counts 0..DIV-1.
  - phase_en = busy && div_cnt==DIV-1. It is combinational from state and is 1 every cycle when DIV=1.
- On an edge with phase_en=1:
  - div_cnt<=0.
  - If ph<PH-1, ph increments.
  - Otherwise ph<=0 and tp rotates left one bit (T12 -> T01).
- Time-pulse and MCT lengths:
  - Each time pulse lasts DIV*PH cycles.
  - An MCT lasts 12*DIV*PH cycles (96 cycles at defaults).
- mct_done = phase_en && tp[11] && ph==PH-1.
- On an edge with mct_done=1:
  - scaler<=scaler+1, modulo 2^SCALER_W.
  - If run=1 and step_only=0, continue at T01.
  - If run=1 and step_only=1, clear step_only and continue at T01.
  - If run=0, go to HALT: tp<=0, ph<=0, busy<=0.
- run deasserted mid-MCT: the current MCT completes fully; it is never truncated.
- step asserted while in RUN: ignored, not queued.
- run and step both 1 in HALT: treated as run.
- run=1 sampled on the final edge of a step MCT converts to continuous run with no gap cycle.
- Reset mid-MCT: immediate return to reset values. No partial MCT is counted in scaler.
- tp is always one-hot in RUN and zero in HALT. No glitch: all outputs are registered except phase_en and mct_done, which are decoded from registers only.

Test Plan:
- Reset mid-run: defaults. Assert rst=0 for 3 cycles at T05 -> tp=0, scaler=0, busy=0 asynchronously. Release with run=1 -> T01 on the second cycle after release.
- Free-run: defaults, run=1 from reset release -> tp=001 for 8 cycles, 002 for 8, ..., 800 for 8, then 001. phase_en every 4th cycle. mct_done at cycle 96. scaler=1 after 96 cycles, 5 after 480.
- Halt at boundary: drop run at T06 -> T06..T12 complete, mct_done pulses once. Next cycle tp=0, busy=0, scaler increments by 1 only.
- Single step: halted, pulse step for 1 cycle -> exactly one 96-cycle MCT then HALT. A second step pulse during that MCT is ignored, so scaler +1 total.
- DIV=1, PH=1: run=1 -> phase_en high every cycle, tp rotates every cycle, mct_done every 12th cycle.
- Scaler wrap: SCALER_W=3, run 8 MCTs -> scaler 7 -> 0 on the 8th mct_done.

Source files
------------

// File: rtl/agc_timepulse_gen.sv
// AGC time-pulse generator: divides clk into phases and one-hot time pulses T01..T12,
// with free-run, halt at MCT boundary, single-MCT step and a wrapping MCT scaler.
module agc_timepulse_gen #(
  parameter int DIV      = 4,
  parameter int PH       = 2,
  parameter int SCALER_W = 17,
  localparam int PH_W    = (PH > 1) ? $clog2(PH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  output logic [11:0]         tp,
  output logic [PH_W-1:0]     ph,
  output logic                phase_en,
  output logic                mct_done,
  output logic                busy,
  output logic [SCALER_W-1:0] scaler
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {S_HALT, S_RUN} state_t;

  state_t                r_state;
  logic [11:0]           r_tp;
  logic [PH_W-1:0]       r_ph;
  logic [DIV_W-1:0]      r_div;
  logic [SCALER_W-1:0]   r_scaler;
  logic                  r_step_only;

  logic w_phase_en;
  logic w_last_ph;
  logic w_mct_done;

  // Strobes decode registers only, so they are glitch-free relative to the edge.
  assign w_phase_en = (r_state == S_RUN) && (r_div == DIV_W'(DIV - 1));
  assign w_last_ph  = (r_ph == PH_W'(PH - 1));
  assign w_mct_done = w_phase_en && r_tp[11] && w_last_ph;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_HALT;
      r_tp        <= '0;
      r_ph        <= '0;
      r_div       <= '0;
      r_scaler    <= '0;
      r_step_only <= 1'b0;
    end else begin
      case (r_state)
        S_HALT: begin
          if (run || step) begin
            r_state     <= S_RUN;
            r_tp        <= 12'h001;
            r_ph        <= '0;
            r_div       <= '0;
            r_step_only <= ~run;
          end
        end
        S_RUN: begin
          if (w_phase_en) begin
            r_div <= '0;
            if (!w_last_ph) begin
              r_ph <= r_ph + PH_W'(1);
            end else begin
              r_ph <= '0;
              r_tp <= {r_tp[10:0], r_tp[11]};
            end
            // End of T12: count the MCT, then either wrap to T01 or park in HALT.
            if (w_mct_done) begin
              r_scaler <= r_scaler + SCALER_W'(1);
              if (run) begin
                if (r_step_only) r_step_only <= 1'b0;
              end else begin
                r_state <= S_HALT;
                r_tp    <= '0;
                r_ph    <= '0;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign tp       = r_tp;
  assign ph       = r_ph;
  assign phase_en = w_phase_en;
  assign mct_done = w_mct_done;
  assign busy     = (r_state == S_RUN);
  assign scaler   = r_scaler;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Scoreboard bench: three configurations driven in lockstep; expectations come from a
// per-configuration cycle-in-MCT model and are compared on the falling edge.
module tb_agc_timepulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] run  = '0;
  logic [2:0] step = '0;

  logic [11:0] tp0, tp1, tp2;
  logic [0:0]  ph0, ph1, ph2;
  logic        pe0, pe1, pe2, md0, md1, md2, bz0, bz1, bz2;
  logic [16:0] sc0, sc1;
  logic [2:0]  sc2;

  always #5 clk = ~clk;

  agc_timepulse_gen #(.DIV(4), .PH(2), .SCALER_W(17)) u_dut0 (
    .clk(clk), .rst(rst), .run(run[0]), .step(step[0]), .tp(tp0), .ph(ph0),
    .phase_en(pe0), .mct_done(md0), .busy(bz0), .scaler(sc0));
  agc_timepulse_gen #(.DIV(1), .PH(1), .SCALER_W(17)) u_dut1 (
    .clk(clk), .rst(rst), .run(run[1]), .step(step[1]), .tp(tp1), .ph(ph1),
    .phase_en(pe1), .mct_done(md1), .busy(bz1), .scaler(sc1));
  agc_timepulse_gen #(.DIV(1), .PH(2), .SCALER_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .run(run[2]), .step(step[2]), .tp(tp2), .ph(ph2),
    .phase_en(pe2), .mct_done(md2), .busy(bz2), .scaler(sc2));

  typedef struct {
    int id; int tp; int ph; int pe; int md; int busy; int sc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  int DV[3] = '{4, 1, 1};
  int PV[3] = '{2, 1, 2};
  int SW[3] = '{17, 17, 3};
  int m_act[3], m_c[3], m_sc[3];

  logic       nx_rst  = 1'b0;
  logic [2:0] nx_run  = '0;
  logic [2:0] nx_step = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    logic [31:0] a_tp, a_ph, a_pe, a_md, a_bz, a_sc;
    case (e.id)
      0: begin a_tp = 32'(tp0); a_ph = 32'(ph0); a_pe = 32'(pe0); a_md = 32'(md0); a_bz = 32'(bz0); a_sc = 32'(sc0); end
      1: begin a_tp = 32'(tp1); a_ph = 32'(ph1); a_pe = 32'(pe1); a_md = 32'(md1); a_bz = 32'(bz1); a_sc = 32'(sc1); end
      default: begin a_tp = 32'(tp2); a_ph = 32'(ph2); a_pe = 32'(pe2); a_md = 32'(md2); a_bz = 32'(bz2); a_sc = 32'(sc2); end
    endcase
    chk($sformatf("d%0d.tp", e.id), a_tp, e.tp);
    chk($sformatf("d%0d.ph", e.id), a_ph, e.ph);
    chk($sformatf("d%0d.phase_en", e.id), a_pe, e.pe);
    chk($sformatf("d%0d.mct_done", e.id), a_md, e.md);
    chk($sformatf("d%0d.busy", e.id), a_bz, e.busy);
    chk($sformatf("d%0d.scaler", e.id), a_sc, e.sc);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_act[d] = 0; m_c[d] = 0; m_sc[d] = 0;
    end
  endtask

  // One clock: check what the last edge produced, drive the next inputs, predict the next edge.
  task automatic tick();
    exp_t e;
    int len;
    @(negedge clk);
    while (q.size() > 0) compare(q.pop_front());
    rst  = nx_rst;
    run  = nx_run;
    step = nx_step;
    for (int d = 0; d < 3; d++) begin
      len = 12 * DV[d] * PV[d];
      if (!nx_rst) begin
        m_act[d] = 0; m_c[d] = 0; m_sc[d] = 0;
      end else if (m_act[d] == 0) begin
        if (nx_run[d] || nx_step[d]) begin m_act[d] = 1; m_c[d] = 0; end
      end else if (m_c[d] == len - 1) begin
        m_sc[d]++;
        if (nx_run[d]) m_c[d] = 0;
        else m_act[d] = 0;
      end else begin
        m_c[d]++;
      end
      e.id = d;
      e.sc = m_sc[d] % (1 << SW[d]);
      if (m_act[d] != 0) begin
        e.tp   = 1 << (m_c[d] / (DV[d] * PV[d]));
        e.ph   = (m_c[d] / DV[d]) % PV[d];
        e.pe   = (m_c[d] % DV[d] == DV[d] - 1) ? 1 : 0;
        e.md   = (m_c[d] == len - 1) ? 1 : 0;
        e.busy = 1;
      end else begin
        e.tp = 0; e.ph = 0; e.pe = 0; e.md = 0; e.busy = 0;
      end
      q.push_back(e);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int reached;
    model_reset();

    nx_rst = 1'b0;
    ticks(3);
    chk("reset.tp", 32'(tp0), 32'h0);
    chk("reset.busy", 32'(bz0), 32'h0);

    // Free run from reset release: dut0 reaches 5 MCTs, dut2 wraps its 3-bit scaler.
    nx_rst = 1'b1;
    nx_run = 3'b111;
    ticks(500);

    // Drop run during T06 of dut0; the MCT must finish before halting.
    reached = 0;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      tick();
      if (m_act[0] != 0 && m_c[0] / 8 == 5) reached = 1;
    end
    chk("reach_T06", 32'(reached), 32'h1);
    nx_run = 3'b000;
    ticks(120);

    // Single step; a second step during dut0's MCT must be ignored.
    nx_step = 3'b111;
    tick();
    nx_step = 3'b000;
    ticks(30);
    nx_step = 3'b111;
    tick();
    nx_step = 3'b000;
    ticks(100);

    // Step, then run sampled on the final edge: continuous run with no gap.
    nx_step = 3'b111;
    tick();
    nx_step = 3'b000;
    reached = 0;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      tick();
      if (m_act[0] != 0 && m_c[0] == 95) reached = 1;
    end
    chk("reach_last", 32'(reached), 32'h1);
    nx_run = 3'b111;
    ticks(40);

    // Asynchronous reset mid-MCT at T05.
    reached = 0;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      tick();
      if (m_act[0] != 0 && m_c[0] / 8 == 4) reached = 1;
    end
    chk("reach_T05", 32'(reached), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async.tp", 32'(tp0), 32'h0);
    chk("async.busy", 32'(bz0), 32'h0);
    chk("async.scaler", 32'(sc0), 32'h0);
    q.delete();
    model_reset();
    nx_rst = 1'b0;
    ticks(3);
    nx_rst = 1'b1;
    nx_run = 3'b111;
    ticks(30);

    @(negedge clk);
    while (q.size() > 0) compare(q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
